// File: rtl/rx_os_detect_multi_pkg.sv
// Shared symbol definitions, ordered-set encodings and code-group helpers
// for the multi-lane ordered-set / disparity checker.
package rx_os_detect_multi_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CODE_W  = 10;
    localparam int unsigned FIELD_W = 40;

    localparam logic [BYTE_W-1:0] SYM_COM = 8'hBC;
    localparam logic [BYTE_W-1:0] SYM_SKP = 8'h1C;
    localparam logic [BYTE_W-1:0] SYM_FTS = 8'h3C;
    localparam logic [BYTE_W-1:0] SYM_IDL = 8'h7C;
    localparam logic [BYTE_W-1:0] SYM_PAD = 8'hF7;
    localparam logic [BYTE_W-1:0] TS1_ID  = 8'h4A;
    localparam logic [BYTE_W-1:0] TS2_ID  = 8'h45;

    // K28.5 in both running-disparity flavours
    localparam logic [CODE_W-1:0] PCOMMA = 10'b0011111010;
    localparam logic [CODE_W-1:0] NCOMMA = 10'b1100000101;

    typedef enum logic [2:0] {
        OS_NONE = 3'd0,
        OS_EIOS = 3'd1,
        OS_FTS  = 3'd2,
        OS_SKP  = 3'd3,
        OS_TS   = 3'd4
    } osType_t;

    typedef enum logic {
        HUNT    = 1'b0,
        OS_BODY = 1'b1
    } laneState_t;

    typedef struct packed {
        logic [BYTE_W-1:0] ctrl;
        logic [BYTE_W-1:0] rate;
        logic [BYTE_W-1:0] nfts;
        logic [BYTE_W-1:0] lane;
        logic [BYTE_W-1:0] link;
    } tsFields_t;

    // K symbol that repeats through an EIOS/FTS/SKP body
    function automatic logic [BYTE_W-1:0] osKSym(input osType_t t);
        logic [BYTE_W-1:0] s;
        case (t)
            OS_EIOS: s = SYM_IDL;
            OS_FTS:  s = SYM_FTS;
            default: s = SYM_SKP;
        endcase
        return s;
    endfunction

    // {non-zero disparity, positive disparity}
    function automatic logic [1:0] codeDisp(input logic [CODE_W-1:0] code);
        int unsigned ones;
        ones = $countones(code);
        return {ones != 5, ones > 5};
    endfunction

    // Any run of six equal bits inside the code group
    function automatic logic runErr(input logic [CODE_W-1:0] code);
        logic r;
        r = 1'b0;
        for (int i = 0; i <= int'(CODE_W) - 6; i++) begin
            if (code[i +: 6] == 6'h3F || code[i +: 6] == 6'h00) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_os_detect_multi_lane.sv
// One lane: ordered-set FSM, TS field shadow, consecutive-TS counter and
// disparity / run-length error counter.
module rx_os_lane
    import rx_os_detect_multi_pkg::*;
#(
    parameter int unsigned TS_CONSEC = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 notReset,
    input  logic                 Synced,
    input  logic                 DecodeCtrl,
    input  logic [BYTE_W-1:0]    DecodeByte,
    input  logic [CODE_W-1:0]    LinkIn,
    input  logic                 ErrClr,
    output logic                 ElecIdleOs,
    output logic                 FtsOs,
    output logic                 SkpOs,
    output logic [1:0]           RxTrainingSeq,
    output logic                 TsConsecOk,
    output tsFields_t            TsFields,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    localparam logic [3:0] CONSEC_MAX = 4'(TS_CONSEC);

    laneState_t         state, stateNxt;
    logic [3:0]         idx, idxNxt;
    osType_t            osType, osTypeNxt;
    logic               isTs2, isTs2Nxt;
    logic [FIELD_W-1:0] shadow, shadowNxt;
    osType_t            done;
    logic               abort;
    logic               isCom;

    logic [3:0]         consecCnt, consecCntNxt;
    logic               lastTs2;
    logic               sameTs;

    logic               dispEn, dispEnNxt;
    logic               rdPos, rdPosNxt;
    logic [1:0]         disp;
    logic               codeErr;

    // Ordered-set recogniser: next state, shadow and completion/abort strobes
    always_comb begin
        stateNxt  = state;
        idxNxt    = idx;
        osTypeNxt = osType;
        isTs2Nxt  = isTs2;
        shadowNxt = shadow;
        done      = OS_NONE;
        abort     = 1'b0;
        isCom     = DecodeCtrl && (DecodeByte == SYM_COM);

        if (!Synced) begin
            stateNxt  = HUNT;
            osTypeNxt = OS_NONE;
        end else if (isCom) begin
            // COM always (re)starts a set; mid-set it also aborts the old one
            stateNxt  = OS_BODY;
            idxNxt    = 4'd1;
            osTypeNxt = OS_NONE;
            abort     = (state == OS_BODY);
        end else if (state == OS_BODY) begin
            idxNxt = idx + 4'd1;
            case (osType)
                OS_NONE: begin
                    if (!DecodeCtrl || DecodeByte == SYM_PAD) begin
                        osTypeNxt = OS_TS;
                        shadowNxt = {DecodeByte, shadow[FIELD_W-1:BYTE_W]};
                    end else if (DecodeByte == SYM_IDL) begin
                        osTypeNxt = OS_EIOS;
                    end else if (DecodeByte == SYM_FTS) begin
                        osTypeNxt = OS_FTS;
                    end else if (DecodeByte == SYM_SKP) begin
                        osTypeNxt = OS_SKP;
                    end else begin
                        abort = 1'b1;
                    end
                end
                OS_EIOS, OS_FTS, OS_SKP: begin
                    if (DecodeCtrl && DecodeByte == osKSym(osType)) begin
                        if (idx == 4'd3) begin
                            done     = osType;
                            stateNxt = HUNT;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
                OS_TS: begin
                    if (idx <= 4'd5) begin
                        if (!DecodeCtrl || DecodeByte == SYM_PAD) begin
                            shadowNxt = {DecodeByte, shadow[FIELD_W-1:BYTE_W]};
                        end else begin
                            abort = 1'b1;
                        end
                    end else if (DecodeCtrl) begin
                        abort = 1'b1;
                    end else if (idx == 4'd6) begin
                        if (DecodeByte == TS1_ID)      isTs2Nxt = 1'b0;
                        else if (DecodeByte == TS2_ID) isTs2Nxt = 1'b1;
                        else                           abort    = 1'b1;
                    end else if (DecodeByte != (isTs2 ? TS2_ID : TS1_ID)) begin
                        abort = 1'b1;
                    end else if (idx == 4'd15) begin
                        done     = OS_TS;
                        stateNxt = HUNT;
                    end
                end
                default: abort = 1'b1;
            endcase
            if (abort) begin
                stateNxt  = HUNT;
                osTypeNxt = OS_NONE;
            end
        end
    end

    // Consecutive identical TS tracking
    always_comb begin
        consecCntNxt = consecCnt;
        sameTs       = (consecCnt != 4'd0) && (isTs2 == lastTs2) &&
                       (shadow == TsFields);
        if (!Synced) begin
            consecCntNxt = 4'd0;
        end else if (done == OS_TS) begin
            if (!sameTs)                      consecCntNxt = 4'd1;
            else if (consecCnt != CONSEC_MAX) consecCntNxt = consecCnt + 4'd1;
        end else if (done == OS_EIOS || done == OS_FTS || abort) begin
            consecCntNxt = 4'd0;
        end
    end

    // Disparity and run-length checking on the raw code group
    always_comb begin
        dispEnNxt = dispEn;
        rdPosNxt  = rdPos;
        codeErr   = 1'b0;
        disp      = codeDisp(LinkIn);
        if (!Synced) begin
            dispEnNxt = 1'b0;
        end else if (!dispEn) begin
            if (LinkIn == PCOMMA || LinkIn == NCOMMA) begin
                dispEnNxt = 1'b1;
                rdPosNxt  = (LinkIn == PCOMMA);
            end
        end else begin
            if (disp[1]) begin
                if (disp[0] == rdPos) codeErr = 1'b1;
                rdPosNxt = disp[0];
            end
            if (runErr(LinkIn)) codeErr = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            state         <= HUNT;
            idx           <= 4'd0;
            osType        <= OS_NONE;
            isTs2         <= 1'b0;
            shadow        <= '0;
            consecCnt     <= 4'd0;
            lastTs2       <= 1'b0;
            TsConsecOk    <= 1'b0;
            TsFields      <= '0;
            ElecIdleOs    <= 1'b0;
            FtsOs         <= 1'b0;
            SkpOs         <= 1'b0;
            RxTrainingSeq <= 2'b00;
            dispEn        <= 1'b0;
            rdPos         <= 1'b0;
            ErrCount      <= '0;
        end else begin
            state         <= stateNxt;
            idx           <= idxNxt;
            osType        <= osTypeNxt;
            isTs2         <= isTs2Nxt;
            shadow        <= shadowNxt;
            consecCnt     <= consecCntNxt;
            TsConsecOk    <= (consecCntNxt == CONSEC_MAX);
            ElecIdleOs    <= (done == OS_EIOS);
            FtsOs         <= (done == OS_FTS);
            SkpOs         <= (done == OS_SKP);
            RxTrainingSeq <= {(done == OS_TS) && isTs2, (done == OS_TS) && !isTs2};
            if (done == OS_TS) begin
                TsFields <= shadow;
                lastTs2  <= isTs2;
            end
            dispEn        <= dispEnNxt;
            rdPos         <= rdPosNxt;
            if (ErrClr)                          ErrCount <= '0;
            else if (codeErr && ErrCount != '1)  ErrCount <= ErrCount + 1'b1;
        end
    end

endmodule

// File: rtl/rx_os_detect_multi.sv
// Multi-lane ordered-set detector: one independent rx_os_lane per lane,
// with per-lane slicing of the packed buses.
module rx_os_detect_multi
    import rx_os_detect_multi_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TS_CONSEC = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                           Clk,
    input  logic                           notReset,
    input  logic [NUM_LANES-1:0]           Synced,
    input  logic [NUM_LANES-1:0]           DecodeCtrl,
    input  logic [BYTE_W*NUM_LANES-1:0]    DecodeByte,
    input  logic [CODE_W*NUM_LANES-1:0]    LinkIn,
    input  logic                           ErrClr,
    output logic [NUM_LANES-1:0]           ElecIdleOs,
    output logic [NUM_LANES-1:0]           FtsOs,
    output logic [NUM_LANES-1:0]           SkpOs,
    output logic [2*NUM_LANES-1:0]         RxTrainingSeq,
    output logic [NUM_LANES-1:0]           TsConsecOk,
    output logic [FIELD_W*NUM_LANES-1:0]   TsFields,
    output logic [ERR_CNT_W*NUM_LANES-1:0] ErrCount
);

    for (genvar g = 0; g < int'(NUM_LANES); g++) begin : gLane
        rx_os_lane #(
            .TS_CONSEC (TS_CONSEC),
            .ERR_CNT_W (ERR_CNT_W)
        ) uLane (
            .Clk           (Clk),
            .notReset      (notReset),
            .Synced        (Synced[g]),
            .DecodeCtrl    (DecodeCtrl[g]),
            .DecodeByte    (DecodeByte[BYTE_W*g +: BYTE_W]),
            .LinkIn        (LinkIn[CODE_W*g +: CODE_W]),
            .ErrClr        (ErrClr),
            .ElecIdleOs    (ElecIdleOs[g]),
            .FtsOs         (FtsOs[g]),
            .SkpOs         (SkpOs[g]),
            .RxTrainingSeq (RxTrainingSeq[2*g +: 2]),
            .TsConsecOk    (TsConsecOk[g]),
            .TsFields      (TsFields[FIELD_W*g +: FIELD_W]),
            .ErrCount      (ErrCount[ERR_CNT_W*g +: ERR_CNT_W])
        );
    end

endmodule

// File: tb/tb_rx_os_detect_multi.sv
// Directed bench for rx_os_detect_multi: TS/EIOS/FTS/SKP decode, consecutive
// TS counting, error counter saturation/clear, Synced drop and async reset.
module tb_rx_os_detect_multi;

    localparam int NL = 4;
    localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, FTS = 8'h3C, IDL = 8'h7C;
    localparam logic [7:0] TS1 = 8'h4A, TS2 = 8'h45;
    localparam logic [9:0] PCOM = 10'b0011111010, NCOM = 10'b1100000101;
    localparam logic [9:0] RUN6 = 10'h3F0, GOOD = 10'b0101010101;
    localparam logic [39:0] F0 = 40'h0002200000, F0L1 = 40'h0002200100;
    localparam logic [39:0] F3 = 40'h0004180305;

    logic           Clk = 1'b0;
    logic           notReset;
    logic [NL-1:0]  Synced, DecodeCtrl;
    logic [8*NL-1:0]  DecodeByte;
    logic [10*NL-1:0] LinkIn;
    logic           ErrClr;
    logic [NL-1:0]  ElecIdleOs, FtsOs, SkpOs, TsConsecOk;
    logic [2*NL-1:0]  RxTrainingSeq;
    logic [40*NL-1:0] TsFields;
    logic [8*NL-1:0]  ErrCount;

    int checks = 0;
    int errors = 0;
    int tsCnt [2*NL] = '{default: 0};
    int eiosCnt [NL] = '{default: 0};
    int ftsCnt [NL]  = '{default: 0};
    int skpCnt [NL]  = '{default: 0};

    rx_os_detect_multi #(.NUM_LANES(NL), .TS_CONSEC(8), .ERR_CNT_W(8)) dut (
        .Clk           (Clk),
        .notReset      (notReset),
        .Synced        (Synced),
        .DecodeCtrl    (DecodeCtrl),
        .DecodeByte    (DecodeByte),
        .LinkIn        (LinkIn),
        .ErrClr        (ErrClr),
        .ElecIdleOs    (ElecIdleOs),
        .FtsOs         (FtsOs),
        .SkpOs         (SkpOs),
        .RxTrainingSeq (RxTrainingSeq),
        .TsConsecOk    (TsConsecOk),
        .TsFields      (TsFields),
        .ErrCount      (ErrCount)
    );

    always #5 Clk = ~Clk;

    // Pulse tallies, sampled mid-cycle
    always @(negedge Clk) begin
        for (int i = 0; i < 2*NL; i++) if (RxTrainingSeq[i]) tsCnt[i]++;
        for (int i = 0; i < NL; i++) begin
            if (ElecIdleOs[i]) eiosCnt[i]++;
            if (FtsOs[i])      ftsCnt[i]++;
            if (SkpOs[i])      skpCnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sym(input int lane, input logic k, input logic [7:0] b);
        DecodeCtrl = '0;
        DecodeByte = '0;
        DecodeCtrl[lane] = k;
        DecodeByte[8*lane +: 8] = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        DecodeCtrl = '0;
        DecodeByte = '0;
        @(posedge Clk);
        #1;
    endtask

    task automatic sendTs(input int lane, input logic is2, input logic [39:0] f);
        sym(lane, 1'b1, COM);
        for (int b = 0; b < 5; b++) sym(lane, 1'b0, f[8*b +: 8]);
        repeat (10) sym(lane, 1'b0, is2 ? TS2 : TS1);
    endtask

    task automatic sendK(input int lane, input logic [7:0] k);
        sym(lane, 1'b1, COM);
        repeat (3) sym(lane, 1'b1, k);
    endtask

    initial begin
        notReset = 1'b0; Synced = '0; DecodeCtrl = '0; DecodeByte = '0;
        LinkIn = '0; ErrClr = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_eios", 64'(ElecIdleOs), 64'(0));
        check("reset_fts", 64'(FtsOs), 64'(0));
        check("reset_skp", 64'(SkpOs), 64'(0));
        check("reset_ts", 64'(RxTrainingSeq), 64'(0));
        check("reset_consec", 64'(TsConsecOk), 64'(0));
        check("reset_fields", 64'(|TsFields), 64'(0));
        check("reset_errcnt", 64'(ErrCount), 64'(0));
        notReset = 1'b1;
        Synced = '1;
        idle(); idle();

        // Lane 0: 8 identical TS1 with a SKP set between #4 and #5
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                sendK(0, SKP);
                check("skp_pulse", 64'(SkpOs), 64'(4'b0001));
            end
            sendTs(0, 1'b0, F0);
            check("ts1_pulse", 64'(RxTrainingSeq), 64'(8'b0000_0001));
            check("consec_a", 64'(TsConsecOk[0]), 64'(i == 7));
        end
        idle();
        check("ts_pulse_width", 64'(RxTrainingSeq), 64'(0));
        check("fields_a", 64'(TsFields[39:0]), 64'(F0));
        check("ts1_count_a", 64'(tsCnt[0]), 64'(8));
        check("skp_count", 64'(skpCnt[0]), 64'(1));
        check("consec_hold", 64'(TsConsecOk[0]), 64'(1));

        // TS2 with identical fields breaks the TS1 streak
        sendTs(0, 1'b1, F0);
        check("ts2_pulse", 64'(RxTrainingSeq[1:0]), 64'(2'b10));
        check("consec_ts2", 64'(TsConsecOk[0]), 64'(0));

        // 7 TS1, then one with lane=1 reloads the count
        for (int i = 0; i < 7; i++) sendTs(0, 1'b0, F0);
        check("consec_7", 64'(TsConsecOk[0]), 64'(0));
        sendTs(0, 1'b0, F0L1);
        check("consec_reload", 64'(TsConsecOk[0]), 64'(0));
        check("fields_l1", 64'(TsFields[39:0]), 64'(F0L1));
        for (int j = 0; j < 7; j++) begin
            sendTs(0, 1'b0, F0L1);
            check("consec_b", 64'(TsConsecOk[0]), 64'(j == 6));
        end
        idle();
        check("ts1_count_b", 64'(tsCnt[0]), 64'(23));
        check("ts2_count_b", 64'(tsCnt[1]), 64'(1));

        // Lane 2: EIOS, aborted EIOS, stray IDL in HUNT, FTS
        sendK(2, IDL);
        check("eios_pulse", 64'(ElecIdleOs), 64'(4'b0100));
        idle();
        check("eios_width", 64'(ElecIdleOs), 64'(0));
        sym(2, 1'b1, COM); sym(2, 1'b1, IDL); sym(2, 1'b1, IDL); sym(2, 1'b0, 8'h05);
        check("eios_abort", 64'(ElecIdleOs), 64'(0));
        sym(2, 1'b1, IDL);
        check("eios_hunt", 64'(ElecIdleOs), 64'(0));
        idle();
        check("eios_count", 64'(eiosCnt[2]), 64'(1));
        sendK(2, FTS);
        check("fts_pulse", 64'(FtsOs), 64'(4'b0100));
        idle();
        check("fts_count", 64'(ftsCnt[2]), 64'(1));

        // Lane 1: run-length errors after comma lock, saturation, clear
        LinkIn[19:10] = PCOM;
        idle();
        LinkIn[19:10] = RUN6;
        repeat (3) idle();
        check("err_count_3", 64'(ErrCount[15:8]), 64'(3));
        repeat (297) idle();
        check("err_saturate", 64'(ErrCount[15:8]), 64'(255));
        ErrClr = 1'b1;
        idle();
        ErrClr = 1'b0;
        check("err_clear", 64'(ErrCount[15:8]), 64'(0));
        LinkIn[19:10] = GOOD;
        repeat (2) idle();
        check("err_neutral", 64'(ErrCount[15:8]), 64'(0));
        LinkIn[19:10] = PCOM;
        idle();
        check("err_disp_pp", 64'(ErrCount[15:8]), 64'(1));
        LinkIn[19:10] = NCOM;
        idle();
        check("err_disp_alt", 64'(ErrCount[15:8]), 64'(1));
        idle();
        check("err_disp_nn", 64'(ErrCount[15:8]), 64'(2));
        LinkIn[19:10] = GOOD;
        Synced[1] = 1'b0;
        idle();
        Synced[1] = 1'b1;
        check("err_hold_unsync", 64'(ErrCount[15:8]), 64'(2));
        check("err_lane0_clean", 64'(ErrCount[7:0]), 64'(0));

        // Lane 3: reach TsConsecOk, then lose sync at byte 9 of the next TS
        for (int i = 0; i < 8; i++) sendTs(3, 1'b0, F3);
        check("consec_l3", 64'(TsConsecOk[3]), 64'(1));
        sym(3, 1'b1, COM);
        for (int b = 0; b < 5; b++) sym(3, 1'b0, F3[8*b +: 8]);
        repeat (3) sym(3, 1'b0, TS1);
        Synced[3] = 1'b0;
        sym(3, 1'b0, TS1);
        Synced[3] = 1'b1;
        check("unsync_consec", 64'(TsConsecOk[3]), 64'(0));
        check("unsync_fields", 64'(TsFields[159:120]), 64'(F3));
        repeat (6) sym(3, 1'b0, TS1);
        check("unsync_no_pulse", 64'(RxTrainingSeq), 64'(0));
        idle();
        check("unsync_count", 64'(tsCnt[6]), 64'(8));

        // Lane 1: async reset in the middle of a TS
        sym(1, 1'b1, COM);
        for (int b = 0; b < 5; b++) sym(1, 1'b0, F0[8*b +: 8]);
        repeat (2) sym(1, 1'b0, TS1);
        #2 notReset = 1'b0;
        #1;
        check("arst_fields", 64'(|TsFields), 64'(0));
        check("arst_errcnt", 64'(ErrCount), 64'(0));
        check("arst_consec", 64'(TsConsecOk), 64'(0));
        check("arst_pulses", 64'({ElecIdleOs, FtsOs, SkpOs, RxTrainingSeq}), 64'(0));
        idle(); idle();
        notReset = 1'b1;
        repeat (8) sym(1, 1'b0, TS1);
        check("arst_no_pulse", 64'(RxTrainingSeq), 64'(0));
        idle();
        check("arst_ts_count", 64'(tsCnt[2]), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
